// File: rtl/dmem_ctrl.sv
// Data-memory controller between the MEM stage and the data SRAM.
// Handles lane steering, load extension, misalignment and wait states.
module dmem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] read_data,
  output logic        misalign,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] W = 4'(WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic        l_we;
  logic [1:0]  l_size;
  logic        l_uns;
  logic [1:0]  l_off;

  logic        aligned;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [31:0] sh;
  logic [31:0] ext;

  always_comb begin
    aligned = 1'b1;
    be_n    = 4'b1111;
    wd_n    = req_wdata;
    unique case (req_size)
      2'b00: begin
        aligned = 1'b1;
        be_n    = 4'b0001 << req_addr[1:0];
        wd_n    = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        aligned = ~req_addr[0];
        be_n    = 4'b0011 << req_addr[1:0];
        wd_n    = {2{req_wdata[15:0]}};
      end
      default: begin
        aligned = (req_addr[1:0] == 2'b00);
        be_n    = 4'b1111;
        wd_n    = req_wdata;
      end
    endcase
  end

  always_comb begin
    sh  = mem_rdata >> {l_off, 3'b000};
    ext = sh;
    unique case (l_size)
      2'b00:   ext = {{24{~l_uns & sh[7]}}, sh[7:0]};
      2'b01:   ext = {{16{~l_uns & sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

  assign stall    = (state == IDLE && req_valid && aligned)
                  || state == ACCESS;
  assign misalign = state == IDLE && req_valid && !aligned;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      l_we      <= 1'b0;
      l_size    <= '0;
      l_uns     <= 1'b0;
      l_off     <= '0;
      read_data <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid && aligned) begin
            l_we      <= req_we;
            l_size    <= req_size;
            l_uns     <= req_unsigned;
            l_off     <= req_addr[1:0];
            cnt       <= W;
            mem_en    <= 1'b1;
            mem_we    <= req_we && (W == 4'd0);
            mem_be    <= be_n;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wdata <= wd_n;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= '0;
            if (!l_we)
              read_data <= ext;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
            // strobe is pre-registered so it lands on the final cycle only
            mem_we <= l_we && (cnt == 4'd1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: instances with W=2, W=0 and W=5
// share one behavioural SRAM and one clock/reset.
module tb_dmem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]        req_valid;
  logic [2:0]        req_we;
  logic [2:0][1:0]   req_size;
  logic [2:0]        req_unsigned;
  logic [2:0][31:0]  req_addr;
  logic [2:0][31:0]  req_wdata;
  logic [2:0]        stall;
  logic [2:0][31:0]  read_data;
  logic [2:0]        misalign;
  logic [2:0]        mem_en;
  logic [2:0]        mem_we;
  logic [2:0][3:0]   mem_be;
  logic [2:0][31:0]  mem_addr;
  logic [2:0][31:0]  mem_wdata;
  logic [2:0][31:0]  mem_rdata;

  logic [31:0] sram [0:255];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_ctrl #(
      .WAIT_CYCLES(g == 0 ? 2 : (g == 1 ? 0 : 5))
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid[g]),
      .req_we      (req_we[g]),
      .req_size    (req_size[g]),
      .req_unsigned(req_unsigned[g]),
      .req_addr    (req_addr[g]),
      .req_wdata   (req_wdata[g]),
      .stall       (stall[g]),
      .read_data   (read_data[g]),
      .misalign    (misalign[g]),
      .mem_en      (mem_en[g]),
      .mem_we      (mem_we[g]),
      .mem_be      (mem_be[g]),
      .mem_addr    (mem_addr[g]),
      .mem_wdata   (mem_wdata[g]),
      .mem_rdata   (mem_rdata[g])
    );
    assign mem_rdata[g] = sram[mem_addr[g][9:2]];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++)
      if (mem_en[i] && mem_we[i])
        for (int b = 0; b < 4; b++)
          if (mem_be[i][b])
            sram[mem_addr[i][9:2]][8*b +: 8] <= mem_wdata[i][8*b +: 8];
  end

  int we_pulses [3];
  always @(negedge clk)
    for (int i = 0; i < 3; i++)
      if (mem_we[i]) we_pulses[i] = we_pulses[i] + 1;

  int checks = 0;
  int errors = 0;

  int          n_stall, n_en, n_we;
  logic [3:0]  last_be;
  logic [31:0] last_wd;
  logic [31:0] rd_done;

  // Drives one request (starting just after a rising edge) until DONE.
  task automatic access(input int i, input logic we, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a,
                        input logic [31:0] wd);
    bit done;
    done = 0;
    n_stall = 0; n_en = 0; n_we = 0;
    last_be = '0; last_wd = '0; rd_done = '0;
    req_valid[i] = 1'b1; req_we[i] = we; req_size[i] = sz;
    req_unsigned[i] = uns; req_addr[i] = a; req_wdata[i] = wd;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (stall[i]) n_stall++;
      if (mem_en[i]) begin
        n_en++; last_be = mem_be[i]; last_wd = mem_wdata[i];
      end
      if (mem_we[i]) n_we++;
      if (!stall[i]) begin
        done = 1; rd_done = read_data[i];
      end
      @(posedge clk); #1;
    end
    req_valid[i] = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_timeout inst=%0d addr=%h: no DONE in 40 cycles", i, a);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({stall[i], misalign[i], mem_en[i], mem_we[i], mem_be[i]} !== 8'h00
          || read_data[i] !== 32'h0 || mem_addr[i] !== 32'h0
          || mem_wdata[i] !== 32'h0) begin
        errors++;
        $display("FAIL reset_values inst=%0d: rd=%h addr=%h wd=%h be=%b en=%b st=%b, required all zero",
                 i, read_data[i], mem_addr[i], mem_wdata[i], mem_be[i], mem_en[i], stall[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word_load();
    access(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h8899AABB);
    access(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    checks++;
    if (n_stall !== 4) begin
      errors++; $display("FAIL lw_stall_cycles got %0d required 4", n_stall);
    end
    checks++;
    if (n_en !== 3 || last_be !== 4'b1111) begin
      errors++;
      $display("FAIL lw_mem_en got en=%0d be=%b required en=3 be=1111", n_en, last_be);
    end
    checks++;
    if (rd_done !== 32'h8899AABB) begin
      errors++; $display("FAIL lw_data got %h required 8899aabb", rd_done);
    end
  endtask

  task automatic test_sub_word_loads();
    logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
    logic [31:0] ex [4] = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB};
    for (int v = 0; v < 4; v++) begin
      access(0, 1'b0, sz[v], un[v], ad[v], 32'h0);
      checks++;
      if (rd_done !== ex[v]) begin
        errors++;
        $display("FAIL subword_load_%0d addr=%h got %h required %h", v, ad[v], rd_done, ex[v]);
      end
    end
  endtask

  task automatic test_stores();
    access(0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h123456CD);
    checks++;
    if (n_we !== 1 || last_be !== 4'b0010 || last_wd !== 32'hCDCDCDCD) begin
      errors++;
      $display("FAIL sb_lanes got we=%0d be=%b wd=%h required 1 0010 cdcdcdcd",
               n_we, last_be, last_wd);
    end
    checks++;
    if (rd_done !== 32'h0000AABB) begin
      errors++; $display("FAIL sb_read_data_hold got %h required 0000aabb", rd_done);
    end
    access(0, 1'b1, 2'b01, 1'b0, 32'h102, 32'h00001234);
    checks++;
    if (n_we !== 1 || last_be !== 4'b1100 || last_wd !== 32'h12341234) begin
      errors++;
      $display("FAIL sh_lanes got we=%0d be=%b wd=%h required 1 1100 12341234",
               n_we, last_be, last_wd);
    end
    checks++;
    if (rd_done !== 32'h0000AABB) begin
      errors++; $display("FAIL sh_read_data_hold got %h required 0000aabb", rd_done);
    end
    access(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
    checks++;
    if (rd_done !== 32'h1234CDBB) begin
      errors++; $display("FAIL store_merge got %h required 1234cdbb", rd_done);
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz [2] = '{2'b10, 2'b01};
    logic [31:0] ad [2] = '{32'h102, 32'h101};
    for (int v = 0; v < 2; v++) begin
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = sz[v];
      req_unsigned[0] = 1'b0; req_addr[0] = ad[v];
      @(negedge clk);
      checks++;
      if (misalign[0] !== 1'b1 || stall[0] !== 1'b0 || mem_en[0] !== 1'b0) begin
        errors++;
        $display("FAIL misalign_%0d got mis=%b stall=%b en=%b required 1 0 0",
                 v, misalign[0], stall[0], mem_en[0]);
      end
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (misalign[0] !== 1'b0 || mem_en[0] !== 1'b0
          || read_data[0] !== 32'h1234CDBB) begin
        errors++;
        $display("FAIL misalign_after_%0d got mis=%b en=%b rd=%h required 0 0 1234cdbb",
                 v, misalign[0], mem_en[0], read_data[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    access(1, 1'b1, 2'b10, 1'b0, 32'h200, 32'hDEADBEEF);
    checks++;
    if (n_stall !== 2 || n_en !== 1 || n_we !== 1) begin
      errors++;
      $display("FAIL w0_sw_timing got stall=%0d en=%0d we=%0d required 2 1 1",
               n_stall, n_en, n_we);
    end
    access(1, 1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
    checks++;
    if (n_stall !== 2 || n_en !== 1) begin
      errors++;
      $display("FAIL w0_lw_timing got stall=%0d en=%0d required 2 1", n_stall, n_en);
    end
    checks++;
    if (rd_done !== 32'hDEADBEEF) begin
      errors++; $display("FAIL w0_lw_data got %h required deadbeef", rd_done);
    end
  endtask

  task automatic test_reset_mid_access();
    int pulses;
    pulses = we_pulses[2];
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_size[2] = 2'b10;
    req_unsigned[2] = 1'b0; req_addr[2] = 32'h300; req_wdata[2] = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; req_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (stall[2] !== 1'b0 || mem_en[2] !== 1'b0 || mem_we[2] !== 1'b0
        || mem_be[2] !== 4'h0 || mem_addr[2] !== 32'h0
        || mem_wdata[2] !== 32'h0 || read_data[2] !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset_values got st=%b en=%b we=%b be=%b addr=%h wd=%h rd=%h required all zero",
               stall[2], mem_en[2], mem_we[2], mem_be[2], mem_addr[2],
               mem_wdata[2], read_data[2]);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (we_pulses[2] !== pulses) begin
      errors++;
      $display("FAIL mid_reset_we got %0d pulses required 0", we_pulses[2] - pulses);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_wins();
    rst = 1'b1;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'b10;
    req_addr[0] = 32'h100;
    @(posedge clk); #1;
    rst = 1'b0; req_valid[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_en[0] !== 1'b0 || stall[0] !== 1'b0 || read_data[0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_wins got en=%b stall=%b rd=%h required 0 0 0",
               mem_en[0], stall[0], read_data[0]);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    req_valid = '0; req_we = '0; req_size = '0; req_unsigned = '0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 3; i++) we_pulses[i] = 0;
    test_reset();
    test_word_load();
    test_sub_word_loads();
    test_stores();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    test_reset_wins();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
